// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants and types for the restoring divider.
//   DIV_WIDTH  : default operand/result width.
//   CNT_WIDTH  : bit-counter width for the default operand width.
//   cnt_width(): counter width needed to count WIDTH-1 down to zero.
//   state_t    : controller states IDLE / CALC / DONE.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

  // Controller state enumeration, kept as plain constants so older tools
  // and netlist viewers see a simple 2-bit encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step: shift {rem, quo} left by one,
// trial-subtract the divisor and either keep the difference (quotient bit 1)
// or restore the shifted remainder (quotient bit 0).
// Ports:
//   rem_in   : partial remainder before the step (always < divisor)
//   quo_in   : dividend/quotient shift register before the step
//   divisor  : divisor magnitude
//   rem_out  : partial remainder after the step
//   quo_out  : shift register after the step, new quotient bit in the LSB
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   shifted;
  logic [1:0]       diff_hi;
  logic [WIDTH-1:0] diff_lo;
  logic             keep;

  // The partial remainder grows to WIDTH+1 bits after the shift.
  assign shifted = {rem_in, quo_in[WIDTH-1]};

  // Subtract in WIDTH+2 bits so the top bit is the borrow/sign.
  assign {diff_hi, diff_lo} = {1'b0, shifted} - {2'b00, divisor};

  // Because rem_in < divisor, a non-negative difference is always below the
  // divisor, so both upper bits are zero exactly when the subtract succeeds.
  assign keep = (diff_hi == 2'b00);

  always_comb begin
    rem_out = shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b0};
    if (keep) begin
      rem_out = diff_lo;
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/restoring_divider32.sv
// -----------------------------------------------------------------------------
// restoring_divider32
// Multi-cycle restoring divider, one quotient bit per clock.
// A start accepted at edge N produces results and a one-cycle done pulse at
// edge N+WIDTH; a zero divisor finishes at edge N+1 with quotient all-ones,
// remainder = dividend and div_by_zero set.
// Optional feature macro: DIV_SIGNED_EN adds the is_signed port and
// two's-complement division (quotient truncated toward zero, remainder takes
// the sign of the dividend). Without it all division is unsigned.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : request, sampled only in IDLE or DONE
//   dividend, divisor   : operands, captured on an accepted start
//   is_signed           : signed-mode select (DIV_SIGNED_EN only)
//   busy                : division in progress
//   done                : one-cycle pulse, results valid
//   quotient, remainder : registered results, held until the next done
//   div_by_zero         : registered zero-divisor flag
// -----------------------------------------------------------------------------
module restoring_divider32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_work;
  logic [WIDTH-1:0] quo_work;
  logic [WIDTH-1:0] div_work;
  logic             zero_div;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH-1:0] result_quo;
  logic [WIDTH-1:0] result_rem;
  logic             div_zero;
  logic             accept;

  assign div_zero = (divisor == '0);
  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign busy     = (state == CALC);
  assign done     = (state == DONE);

`ifdef DIV_SIGNED_EN
  logic neg_quo;
  logic neg_rem;

  // Signed mode divides magnitudes; the most negative value maps onto itself,
  // which is still the correct unsigned magnitude.
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    if (is_signed && dividend[WIDTH-1]) dividend_mag = -dividend;
    if (is_signed && divisor[WIDTH-1])  divisor_mag  = -divisor;
  end

  // Sign fix-up applied to the final step's outputs as they are loaded.
  assign result_quo = neg_quo ? -step_quo : step_quo;
  assign result_rem = neg_rem ? -step_rem : step_rem;

  // Result signs are decided from the raw operands at capture time.
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      neg_quo <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_rem <= is_signed && dividend[WIDTH-1];
    end
  end
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
  assign result_quo   = step_quo;
  assign result_rem   = step_rem;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_work),
    .quo_in (quo_work),
    .divisor(div_work),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  // Controller and datapath. A zero divisor still spends one cycle in CALC
  // (count loaded with zero) so its results appear one edge after capture;
  // the raw dividend is parked in quo_work to become the remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      rem_work    <= '0;
      quo_work    <= '0;
      div_work    <= '0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          rem_work <= step_rem;
          quo_work <= step_quo;
          if (count == '0) begin
            state <= DONE;
            if (zero_div) begin
              quotient    <= '1;
              remainder   <= quo_work;
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= result_quo;
              remainder   <= result_rem;
              div_by_zero <= 1'b0;
            end
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          if (accept) begin
            state    <= CALC;
            rem_work <= '0;
            div_work <= divisor_mag;
            quo_work <= div_zero ? dividend : dividend_mag;
            zero_div <= div_zero;
            count    <= div_zero ? '0 : CW'(WIDTH - 1);
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/restoring_divider32.md
RESTORING_DIVIDER32 -- requirements
Module: restoring_divider32

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; only 32 is verified.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request; sampled only when the block is ready (state IDLE or DONE).
REQ-005 dividend  input  WIDTH  numerator; captured on an accepted start.
REQ-006 divisor  input  WIDTH  denominator; captured on an accepted start.
REQ-007 is_signed  input  1  signed-mode select; present only when DIV_SIGNED_EN is defined.
REQ-008 busy  output  1  high while a division is in progress.
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 quotient  output  WIDTH  registered quotient result.
REQ-011 remainder  output  WIDTH  registered remainder result.
REQ-012 div_by_zero  output  1  registered flag; valid while done is high, held afterwards.

Function
REQ-013 States SHALL be IDLE, CALC and DONE.
REQ-014 IDLE->CALC SHALL occur on start=1 with divisor!=0; the block SHALL capture operands, load bit counter = WIDTH-1, clear the partial remainder and set busy=1.
REQ-015 CALC SHALL perform one restoring step per cycle:
- shift {rem, quo} left 1 bit;
- trial-subtract the divisor from the WIDTH+1-bit partial remainder;
- set the quotient LSB=1 and keep the difference if it is non-negative, else restore.
REQ-016 CALC->DONE SHALL occur after exactly WIDTH CALC cycles; with start accepted at edge N, results load and done=1 from edge N+WIDTH, busy=0 from the same edge.
REQ-017 On start with divisor==0, the block SHALL go directly to DONE at edge N+1 with quotient=all-ones, remainder=dividend and div_by_zero=1.
REQ-018 DONE SHALL last one cycle, then go to IDLE; start=1 while in DONE SHALL be accepted (back-to-back, no idle cycle).
REQ-019 start while busy=1 SHALL be ignored; operands are not re-captured.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next DONE; they SHALL NOT change during CALC.
REQ-021 Unsigned results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-022 rst=1 SHALL force IDLE at the next edge, including mid-CALC, and abandon the operation with no done pulse.
REQ-023 Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.

Configuration
REQ-024 With DIV_SIGNED_EN defined:
- is_signed=1 SHALL divide two's-complement magnitudes (absolute values taken at capture);
- the quotient is truncated toward zero and negated if the operand signs differ;
- the remainder takes the sign of the dividend;
- 0x80000000 / 0xFFFFFFFF SHALL give quotient=0x80000000, remainder=0;
- latency is unchanged.
REQ-025 Without DIV_SIGNED_EN, the is_signed port and the sign logic SHALL be absent and all division is unsigned.

Structure
REQ-026 Package div_pkg SHALL hold the state enum (IDLE/CALC/DONE), the default-width constant and the counter-width constant.
REQ-027 A combinational sub-module div_step SHALL implement one shift/trial-subtract/restore step; restoring_divider32 instantiates it once.

Verification
REQ-028 100/7 unsigned, start at edge N -> done=1 at edge N+32, quotient=14, remainder=2, div_by_zero=0, busy low from edge N+32.
REQ-029 5/0 -> done at edge N+1, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-030 0xFFFFFFFF/1, then start held high in the DONE cycle with 9/3 -> first result q=0xFFFFFFFF, r=0; second result q=3, r=0 exactly 32 cycles later; start pulses during busy ignored.
REQ-031 rst asserted at edge N+10 of 1000/3 -> busy=0, done=0, quotient=0, remainder=0 after that edge; no done pulse follows.
REQ-032 DIV_SIGNED_EN, is_signed=1:
- -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF;
- 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
